wishbone_sram_slave: RTL
========================

# wishbone_sram_slave

Wishbone classic-cycle responder fronting an on-chip 16-bit word SRAM, with programmable wait states, byte-lane writes and address-range error reporting. Sits on the CPU-side Wishbone bus as the terminating peer of the CPU's Wishbone master. It gives the master a memory target with deterministic ack/err timing.

## Interface
Parameters:
- MEM_AW, 10, word-address width of the internal array (1024 x 16 bit).
- WAIT_CYCLES, 1, wait states inserted between request acceptance and ack/err; legal range 0..15.
- BASE_PAGE, 0, required value of wb_adr[`WB_ADDR_W-1:MEM_AW]; any other value is out of range.

Ports:
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- wb_cyc  in  1  bus cycle active.
- wb_stb  in  1  strobe; request valid.
- wb_we  in  1  1 = write, 0 = read.
- wb_adr  in  `WB_ADDR_W  word address.
- wb_i_dat  in  16  write data.
- wb_sel  in  2  byte-lane enables; bit1 = [15:8], bit0 = [7:0].
- wb_o_dat  out  16  read data; valid only while wb_ack = 1.
- wb_ack  out  1  one-cycle completion pulse.
- wb_err  out  1  one-cycle error pulse for an out-of-range address.
- wb_rty  out  1  tied to 0.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: when wb_cyc & wb_stb, latch adr, we, dat and sel, and compute in_range. Go to WAIT if WAIT_CYCLES > 0, else RESP. Load the wait counter with WAIT_CYCLES-1.
- WAIT: decrement the counter while wb_cyc = 1. At counter 0, go to RESP. If wb_cyc = 0 in WAIT, abort: go to IDLE with no write, no ack and no err.
- RESP: assert wb_ack for exactly one cycle if in_range, else wb_err. Return to IDLE unconditionally.
- Writes commit on the edge entering RESP, only when in_range and per set wb_sel bit. wb_sel = 0 writes nothing but still acks.
- Read data is taken from the array on the edge entering RESP and held in wb_o_dat during RESP. It is 0 on err, on writes, and in every non-RESP cycle.
- The address check is a full compare of the upper bits against BASE_PAGE. An out-of-range access never touches the array.
- A new request is accepted no earlier than the cycle after RESP. Back-to-back requests are therefore spaced by WAIT_CYCLES+2 cycles.
- wb_ack and wb_err are never asserted together, and never in two consecutive cycles.

## Timing
- Reset values: wb_ack = 0, wb_err = 0, wb_o_dat = 0, wb_rty = 0, state IDLE, counter 0. Array contents are not reset.
- Latency: request first sampled at cycle 0; wb_ack/wb_err asserted in cycle 1+WAIT_CYCLES.
- Reset asserted mid-operation (WAIT or RESP): the FSM is in IDLE with outputs 0 in the next cycle. No pending write commits.
- Masters that drop stb on the ack edge see no duplicate acceptance. IDLE ignores the stb still high during the RESP cycle because acceptance only occurs in IDLE.
- Address and data changing during WAIT have no effect; the latched values are used.

## Structure
- `WB_ADDR_W` and `RW` come from config.v. Add `WB_DATA_W` (16) and `WB_SEL_BITS` (2) to config.v as shared defines, replacing the local defines elsewhere.
- Define the FSM state encodings as localparams in this module.
- Sub-module sram_1rw_be: synchronous single-port array.
  - Ports: clk, en, we, be[1:0], addr[MEM_AW-1:0], wdata, rdata.
  - Read-first behaviour; inferable as block RAM.

## Test plan
- Reset, WAIT_CYCLES=1: write adr 0x000005, data 0xBEEF, sel 11 -> wb_ack in cycle 2. Read adr 5 -> wb_o_dat = 0xBEEF in its ack cycle.
- Byte lanes: write 0x1234 sel 11, then 0xAB00 sel 10 -> read returns 0xAB34. Write with sel 00 -> ack, and the data is unchanged.
- Out of range, MEM_AW=10, BASE_PAGE=0: read adr 0x000400 -> wb_err pulse in cycle 2, wb_ack = 0, wb_o_dat = 0. Write to 0x000400 leaves word 0 unchanged.
- Abort: WAIT_CYCLES=3, write 0x5555 to adr 7, drop wb_cyc in cycle 2 -> no ack or err. Subsequent read of adr 7 returns the old value.
- WAIT_CYCLES=0: read -> ack in cycle 1. Back-to-back requests with stb held high -> acks in cycles 1 and 3.
- Reset mid-WAIT, WAIT_CYCLES=4: assert i_rst in cycle 2 -> outputs 0 in cycle 3, no ack afterward, target word unchanged.

Source files
------------

// File: rtl/wishbone_sram_slave_pkg.sv
// Shared widths and types for the Wishbone SRAM responder.
package wishbone_sram_slave_pkg;

  localparam int WB_ADDR_W   = 24;
  localparam int WB_DATA_W   = 16;
  localparam int WB_SEL_BITS = 2;

  // Request fields captured at acceptance; the word address is kept
  // separately because its width depends on the array size.
  typedef struct packed {
    logic                   we;
    logic                   in_range;
    logic [WB_SEL_BITS-1:0] sel;
    logic [WB_DATA_W-1:0]   dat;
  } req_t;

endpackage

// File: rtl/wishbone_sram_slave_if.sv
// Wishbone classic bus between the CPU master and the SRAM responder.
interface wishbone_sram_slave_if;
  import wishbone_sram_slave_pkg::*;

  logic                   cyc;
  logic                   stb;
  logic                   we;
  logic [WB_ADDR_W-1:0]   adr;
  logic [WB_DATA_W-1:0]   wdat;
  logic [WB_SEL_BITS-1:0] sel;
  logic [WB_DATA_W-1:0]   rdat;
  logic                   ack;
  logic                   err;
  logic                   rty;

  modport master (
    output cyc, stb, we, adr, wdat, sel,
    input  rdat, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, wdat, sel,
    output rdat, ack, err, rty
  );

endinterface

// File: rtl/wishbone_sram_slave_sram_1rw_be.sv
// Synchronous single-port word array with byte-lane write enables.
// Read-first: a write cycle returns the word's previous contents.
module sram_1rw_be
  import wishbone_sram_slave_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [WB_SEL_BITS-1:0] be,
  input  logic [MEM_AW-1:0]      addr,
  input  logic [WB_DATA_W-1:0]   wdata,
  output logic [WB_DATA_W-1:0]   rdata
);

  logic [WB_DATA_W-1:0] mem [1 << MEM_AW];

  // Registered read of the old word plus per-lane write on enabled cycles.
  // NOTE: the array has no reset so that it maps onto block RAM; only the
  // control logic around it is reset.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        if (be[0]) mem[addr][7:0]  <= wdata[7:0];
        if (be[1]) mem[addr][15:8] <= wdata[15:8];
      end
    end
  end

endmodule

// File: rtl/wishbone_sram_slave.sv
// Wishbone classic-cycle responder in front of a 16-bit word SRAM with
// programmable wait states, byte-lane writes and out-of-page error replies.
module wishbone_sram_slave
  import wishbone_sram_slave_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int WAIT_CYCLES = 1,   // 0..15
  parameter int BASE_PAGE   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  wishbone_sram_slave_if.slave wb
);

  localparam int                PAGE_W    = WB_ADDR_W - MEM_AW;
  localparam logic [PAGE_W-1:0] PAGE      = PAGE_W'(BASE_PAGE);
  localparam bit                NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0]        WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    RESP = ST_RESP
  } state_t;

  state_t               state;
  logic [3:0]           cnt;
  req_t                 lat;
  logic [MEM_AW-1:0]    lat_adr;
  logic                 ack_q;
  logic                 err_q;
  logic                 rd_valid;

  req_t                 bus_req;
  req_t                 cur_req;
  logic [MEM_AW-1:0]    cur_adr;
  logic                 accept;
  logic                 to_resp;
  logic                 ram_en;
  logic [WB_DATA_W-1:0] ram_rdata;

  // Decode acceptance and the transition into RESP; the array is accessed on
  // that transition, straight from the bus when there are no wait states.
  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    bus_req = '{we:       wb.we,
                in_range: (wb.adr[WB_ADDR_W-1:MEM_AW] == PAGE),
                sel:      wb.sel,
                dat:      wb.wdat};
    accept  = (state == IDLE) && wb.cyc && wb.stb;
    to_resp = (accept && NO_WAIT) ||
              ((state == WAIT) && wb.cyc && (cnt == 4'd0));
    cur_req = (state == IDLE) ? bus_req : lat;
    cur_adr = (state == IDLE) ? wb.adr[MEM_AW-1:0] : lat_adr;
    // An out-of-page request, or one overtaken by reset, never touches the array.
    ram_en  = to_resp && cur_req.in_range && !i_rst;
  end

  // Request FSM with registered ack/err and read-data qualifier.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat      <= '0;
      lat_adr  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      ack_q    <= to_resp && cur_req.in_range;
      err_q    <= to_resp && !cur_req.in_range;
      rd_valid <= to_resp && cur_req.in_range && !cur_req.we;
      case (state)
        IDLE: begin
          if (accept) begin
            lat     <= bus_req;
            lat_adr <= wb.adr[MEM_AW-1:0];
            if (NO_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          // Dropping cyc abandons the request silently.
          if (!wb.cyc) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sram_1rw_be #(
    .MEM_AW (MEM_AW)
  ) u_sram (
    .clk   (i_clk),
    .en    (ram_en),
    .we    (cur_req.we),
    .be    (cur_req.sel),
    .addr  (cur_adr),
    .wdata (cur_req.dat),
    .rdata (ram_rdata)
  );

  assign wb.ack  = ack_q;
  assign wb.err  = err_q;
  assign wb.rty  = 1'b0;
  assign wb.rdat = rd_valid ? ram_rdata : '0;

endmodule
